// File: rtl/rvcpu_fetch.sv
// Instruction-fetch stage: owns the PC, keeps one request in flight and buffers
// returned opcodes in a 2-entry queue feeding decode as {pc, opcode} pairs.
module rvcpu_fetch #(
  parameter int unsigned      Width   = 32,
  parameter logic [Width-1:0] ResetPc = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [Width-1:0]   imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [31:0]        imem_rsp_data,
  input  logic               imem_rsp_err,
  input  logic               redirect_valid,
  input  logic [Width-1:0]   redirect_pc,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [Width+31:0]  if_stage,
  output logic               if_fault
);

  localparam logic [31:0] Nop = 32'h0000_0013;

  typedef struct packed {
    logic [Width-1:0] pc;
    logic [31:0]      opcode;
  } stage_if_t;

  typedef struct packed {
    stage_if_t s;
    logic      fault;
  } entry_t;

  logic [Width-1:0] pc_q, pc_d;
  logic [Width-1:0] req_pc_q, req_pc_d;
  logic             outstanding_q, outstanding_d;
  logic             kill_q, kill_d;
  logic [1:0]       count_q, count_d;
  logic             rd_ptr_q, rd_ptr_d;
  entry_t           q_q [2];
  entry_t           q_d [2];

  logic      req_fire, rsp_fire, rsp_push, pop, wr_ptr;
  entry_t    head, new_ent;
  stage_if_t idle;

  // Issue only with a free slot guaranteed for the reply; redirect blocks issue.
  always_comb begin
    imem_req_valid = rst_n && !outstanding_q && (count_q < 2'd2) && !redirect_valid;
    imem_req_addr  = pc_q & ~Width'(3);
    head           = q_q[rd_ptr_q];
    idle.pc        = '0;
    idle.opcode    = Nop;
    if_valid       = (count_q != 2'd0);
    if_stage       = if_valid ? head.s : idle;
    if_fault       = if_valid && head.fault;
  end

  always_comb begin
    req_fire        = imem_req_valid && imem_req_ready;
    rsp_fire        = imem_rsp_valid && outstanding_q;
    rsp_push        = rsp_fire && !kill_q && !redirect_valid;
    pop             = if_valid && if_ready;
    wr_ptr          = rd_ptr_q ^ count_q[0];
    new_ent.s.pc     = req_pc_q;
    new_ent.s.opcode = imem_rsp_err ? Nop : imem_rsp_data;
    new_ent.fault    = imem_rsp_err;

    pc_d          = pc_q;
    req_pc_d      = req_pc_q;
    outstanding_d = outstanding_q;
    kill_d        = kill_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    q_d           = q_q;

    if (redirect_valid) begin
      // A reply still owed for a stale fetch must be swallowed when it lands.
      pc_d          = redirect_pc & ~Width'(3);
      outstanding_d = outstanding_q && !rsp_fire;
      kill_d        = outstanding_q && !rsp_fire;
      count_d       = 2'd0;
      rd_ptr_d      = 1'b0;
    end else begin
      if (req_fire) begin
        outstanding_d = 1'b1;
        req_pc_d      = pc_q;
        pc_d          = pc_q + Width'(4);
      end else if (rsp_fire) begin
        outstanding_d = 1'b0;
      end
      if (rsp_fire && kill_q) kill_d = 1'b0;
      if (rsp_push) q_d[wr_ptr] = new_ent;
      if (pop) rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + {1'b0, rsp_push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= ResetPc;
      req_pc_q      <= ResetPc;
      outstanding_q <= 1'b0;
      kill_q        <= 1'b0;
      count_q       <= 2'd0;
      rd_ptr_q      <= 1'b0;
      q_q[0]        <= '0;
      q_q[1]        <= '0;
    end else begin
      pc_q          <= pc_d;
      req_pc_q      <= req_pc_d;
      outstanding_q <= outstanding_d;
      kill_q        <= kill_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      q_q           <= q_d;
    end
  end

endmodule
